// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer: frames a complex sample stream for a free-running
// 8-point FFT core. The core has no handshake and a fixed register latency.
//
// Flow: LOAD collects eight samples, WAIT sits out the core latency, and
// UNLOAD streams bins X0..X7 in natural order. Frames never overlap.
//
// Optional build macro FFT_SEQ_FRAMECNT_EN adds frame_cnt[15:0]. This counter
// steps on every bin-7 output handshake and wraps from 0xFFFF to 0.
//
// Handshake rule on both streams: a transfer happens on a rising clk edge
// where valid && ready are both high. A source holds its payload stable while
// valid && !ready. s_ready and m_valid come straight from registers.
module fft8_frame_sequencer #(
  parameter int W        = 8,
  parameter int CORE_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_re,
  input  logic [W-1:0]   s_im,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_re,
  output logic [W-1:0]   m_im,
  output logic [2:0]     m_idx,
  output logic           m_last,
  output logic           busy,
  output logic [8*W-1:0] core_in_re,
  output logic [8*W-1:0] core_in_im,
  input  logic [8*W-1:0] core_out_re,
  input  logic [8*W-1:0] core_out_im
`ifdef FFT_SEQ_FRAMECNT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);

  // The wait counter only needs to cover CORE_LAT in the range 1..7.
  localparam logic [2:0] LAT = 3'(CORE_LAT);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_WAIT   = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       s_ready_nxt;
  logic       m_valid_nxt;

  logic [2:0] cnt;   // next input slot to write
  logic [2:0] wcnt;  // remaining core-latency cycles

  logic [W-1:0] ibuf_re [8];
  logic [W-1:0] ibuf_im [8];
  logic [W-1:0] obuf_re [8];
  logic [W-1:0] obuf_im [8];

  logic s_acc;      // input sample transfer this edge
  logic last_acc;   // transfer of the eighth sample
  logic wait_done;  // core output is valid for the held frame
  logic m_hs;       // output bin transfer this edge
  logic last_hs;    // transfer of bin 7

  assign s_acc     = s_valid && s_ready && (state == S_LOAD);
  assign last_acc  = s_acc && (cnt == 3'd7);
  assign wait_done = (state == S_WAIT) && (wcnt == 3'd0);
  assign m_hs      = m_valid && m_ready && (state == S_UNLOAD);
  assign last_hs   = m_hs && (m_idx == 3'd7);

  // State register plus the registered handshake flags it drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= s_ready_nxt;
      m_valid <= m_valid_nxt;
    end
  end

  // Next state and next handshake flags; every target defaults to its hold value.
  always_comb begin
    state_nxt   = state;
    s_ready_nxt = s_ready;
    m_valid_nxt = m_valid;
    case (state)
      S_LOAD: begin
        s_ready_nxt = 1'b1;
        m_valid_nxt = 1'b0;
        if (last_acc) begin
          state_nxt   = S_WAIT;
          s_ready_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        s_ready_nxt = 1'b0;
        m_valid_nxt = 1'b0;
        if (wait_done) begin
          state_nxt   = S_UNLOAD;
          m_valid_nxt = 1'b1;
        end
      end
      S_UNLOAD: begin
        s_ready_nxt = 1'b0;
        m_valid_nxt = 1'b1;
        if (last_hs) begin
          state_nxt   = S_LOAD;
          m_valid_nxt = 1'b0;
          s_ready_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = S_LOAD;
        s_ready_nxt = 1'b0;
        m_valid_nxt = 1'b0;
      end
    endcase
  end

  // Sample counter: advances per accepted sample and is cleared when bin 7 leaves.
  // Accepting slot 7 wraps it to 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (s_acc) begin
      cnt <= cnt + 3'd1;
    end else if (last_hs) begin
      cnt <= 3'd0;
    end
  end

  // Wait counter: loaded with the core latency on the last accept and run down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 3'd0;
    end else if (last_acc) begin
      wcnt <= LAT;
    end else if ((state == S_WAIT) && (wcnt != 3'd0)) begin
      wcnt <= wcnt - 3'd1;
    end
  end

  // Input frame buffer: written only by accepted samples, so the core input holds
  // steady through WAIT and UNLOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        ibuf_re[k] <= '0;
        ibuf_im[k] <= '0;
      end
    end else if (s_acc) begin
      ibuf_re[cnt] <= s_re;
      ibuf_im[cnt] <= s_im;
    end
  end

  // Pack the input frame for the core: slot k maps to bits [W*k +: W].
  always_comb begin
    core_in_re = '0;
    core_in_im = '0;
    for (int k = 0; k < 8; k++) begin
      core_in_re[W*k +: W] = ibuf_re[k];
      core_in_im[W*k +: W] = ibuf_im[k];
    end
  end

  // Spectrum capture: snapshot all eight bins once the core latency has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        obuf_re[k] <= '0;
        obuf_im[k] <= '0;
      end
    end else if (wait_done) begin
      for (int k = 0; k < 8; k++) begin
        obuf_re[k] <= core_out_re[W*k +: W];
        obuf_im[k] <= core_out_im[W*k +: W];
      end
    end
  end

  // Bin index: steps per output handshake and wraps to 0 after bin 7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx <= 3'd0;
    end else if (m_hs) begin
      m_idx <= m_idx + 3'd1;
    end
  end

  // Output payload is a mux of the captured spectrum. It is stable whenever
  // m_idx is not advancing.
  always_comb begin
    m_re   = obuf_re[m_idx];
    m_im   = obuf_im[m_idx];
    m_last = (m_idx == 3'd7);
    busy   = (state != S_LOAD) || (cnt != 3'd0);
  end

`ifdef FFT_SEQ_FRAMECNT_EN
  // Completed-frame counter: steps on each bin-7 handshake and wraps at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (last_hs) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Bench for fft8_frame_sequencer. It includes a behavioural 8-point DFT core
// with CORE_LAT register stages. Expected bins are constants pushed to a queue
// when a frame is driven; they are popped when the DUT hands the bins over.
// Build with FFT_SEQ_FRAMECNT_EN defined to also check frame_cnt.
module tb_fft8_frame_sequencer;
  localparam int  W        = 8;
  localparam int  CORE_LAT = 1;
  localparam real PI       = 3.14159265358979323846;
  localparam int  EW       = 2*W + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [W-1:0]   s_re, s_im, m_re, m_im;
  logic [2:0]     m_idx;
  logic [8*W-1:0] core_in_re, core_in_im, core_out_re, core_out_im;
`ifdef FFT_SEQ_FRAMECNT_EN
  logic [15:0]    frame_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_edge = 0;
  int exp_fc = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  fr_re[8], fr_im[8], er[8], ei[8];

  fft8_frame_sequencer #(.W(W), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .busy(busy),
    .core_in_re(core_in_re), .core_in_im(core_in_im),
    .core_out_re(core_out_re), .core_out_im(core_out_im)
`ifdef FFT_SEQ_FRAMECNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: DFT X_k = sum x_n * exp(-j*2*pi*k*n/8), rounded.
  function automatic logic [8*W-1:0] dft(input logic [8*W-1:0] xr,
                                         input logic [8*W-1:0] xi,
                                         input bit want_im);
    logic [8*W-1:0] r;
    real ar, ai, ang;
    int  vr, vi, q;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        vr  = int'($signed(xr[W*n +: W]));
        vi  = int'($signed(xi[W*n +: W]));
        ang = 2.0 * PI * real'(k * n) / 8.0;
        ar  = ar + real'(vr) * $cos(ang) + real'(vi) * $sin(ang);
        ai  = ai + real'(vi) * $cos(ang) - real'(vr) * $sin(ang);
      end
      q = want_im ? int'(ai) : int'(ar);
      r[W*k +: W] = W'(q);
    end
    return r;
  endfunction

  logic [8*W-1:0] pipe_re [CORE_LAT];
  logic [8*W-1:0] pipe_im [CORE_LAT];
  always @(posedge clk) begin
    pipe_re[0] <= dft(core_in_re, core_in_im, 1'b0);
    pipe_im[0] <= dft(core_in_re, core_in_im, 1'b1);
    for (int i = 1; i < CORE_LAT; i++) begin
      pipe_re[i] <= pipe_re[i-1];
      pipe_im[i] <= pipe_im[i-1];
    end
  end
  assign core_out_re = pipe_re[CORE_LAT-1];
  assign core_out_im = pipe_im[CORE_LAT-1];

  // global time limit
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int kind);
    for (int k = 0; k < 8; k++) begin
      fr_im[k] = '0;
      er[k]    = '0;
      ei[k]    = '0;
      case (kind)
        0: fr_re[k] = (k == 0) ? W'(1) : '0;        // impulse
        1: fr_re[k] = W'(2);                        // DC
        default: fr_re[k] = (k % 2 == 0) ? W'(1) : W'(-1); // alternating
      endcase
    end
    case (kind)
      0: for (int k = 0; k < 8; k++) er[k] = W'(1);
      1: er[0] = W'(16);
      default: er[4] = W'(8);
    endcase
  endtask

  task automatic push_expected();
    for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), er[k], ei[k]});
  endtask

  // driver: eight samples, each offered at a negedge where s_ready is high
  task automatic send_frame();
    int n;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("s_ready_wait", 64'(n < 200), 64'd1);
      s_valid = 1'b1;
      s_re    = fr_re[k];
      s_im    = fr_im[k];
      if (k == 7) acc_edge = cyc + 1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_re    = W'($urandom_range(0, 255));
    check("s_ready_after_last", 64'(s_ready), 64'd0);
    check("busy_wait", 64'(busy), 64'd1);
    check("m_valid_in_wait", 64'(m_valid), 64'd0);
  endtask

  // receiver: compares the queue head at every negedge with m_valid high
  task automatic recv_frame(input bit bp, input int nbins);
    int got = 0;
    int n   = 0;
    int pat = 0;
    bit first = 1'b1;
    logic [EW-1:0] e;
    while (got < nbins && n < 500) begin
      @(negedge clk);
      n++;
      m_ready = bp ? (pat % 3 == 0) : 1'b1;
      pat++;
      if (bp) begin
        s_valid = 1'b1;
        s_re    = W'($urandom_range(0, 255));
        s_im    = W'($urandom_range(0, 255));
      end
      if (m_valid) begin
        if (first) begin
          check("first_valid_latency", 64'(cyc - acc_edge), 64'(CORE_LAT + 1));
          first = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_bin", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          check("m_idx",   64'(m_idx),  64'(e[EW-1 -: 3]));
          check("m_re",    64'(m_re),   64'(e[2*W-1 -: W]));
          check("m_im",    64'(m_im),   64'(e[W-1:0]));
          check("m_last",  64'(m_last), 64'(e[EW-1 -: 3] == 3'd7));
          check("s_ready_unload", 64'(s_ready), 64'd0);
          check("busy_unload",    64'(busy),    64'd1);
          if (m_ready) begin
            void'(exp_q.pop_front());
            got++;
            if (e[EW-1 -: 3] == 3'd7) exp_fc++;
          end
        end
      end
    end
    check("recv_count", 64'(got), 64'(nbins));
    if (nbins == 8) begin
      @(negedge clk);
      s_valid = 1'b0;
      check("m_valid_after_last", 64'(m_valid), 64'd0);
      check("s_ready_after_unload", 64'(s_ready), 64'd1);
      check("m_idx_after_last", 64'(m_idx), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
`ifdef FFT_SEQ_FRAMECNT_EN
      check("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
`endif
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_re"},    64'(m_re),    64'd0);
    check({tag, "_m_im"},    64'(m_im),    64'd0);
    check({tag, "_m_idx"},   64'(m_idx),   64'd0);
    check({tag, "_m_last"},  64'(m_last),  64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_core_in_re"}, 64'(core_in_re), 64'd0);
    check({tag, "_core_in_im"}, 64'(core_in_im), 64'd0);
`ifdef FFT_SEQ_FRAMECNT_EN
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
`endif
  endtask

  // directed sequence
  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_re = '0; s_im = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1 check("s_ready_before_edge", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("s_ready_after_reset", 64'(s_ready), 64'd1);

    // impulse, with m_ready already high while nothing is valid
    m_ready = 1'b1;
    set_frame(0); push_expected(); send_frame(); recv_frame(1'b0, 8);
    // DC
    set_frame(1); push_expected(); send_frame(); recv_frame(1'b0, 8);
    // alternating
    set_frame(2); push_expected(); send_frame(); recv_frame(1'b0, 8);
    // backpressure on a DC frame, stray s_valid during WAIT/UNLOAD
    set_frame(1); push_expected(); send_frame(); recv_frame(1'b1, 8);
    // a frame after the stray s_valid activity must still start at slot 0
    set_frame(2); push_expected(); send_frame(); recv_frame(1'b0, 8);

    // reset in the middle of UNLOAD, right after the bin-3 handshake
    set_frame(0); push_expected(); send_frame(); recv_frame(1'b0, 4);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_q.delete();
    exp_fc = 0;
    @(negedge clk);
    rst = 1'b0;
    set_frame(0); push_expected(); send_frame(); recv_frame(1'b0, 8);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
- Serial-to-parallel front end and parallel-to-serial back end for the free-running 8-point `fft` core. The core has no handshake and a fixed register latency.
- Accepts complex samples one per handshake and presents a stable 8-sample frame to the core. It waits out the core latency, captures the spectrum, then streams bins X0..X7 one per handshake in natural order.
- Sits between the sample-stream source and the spectrum consumer; the `fft` instance lives beside it at the same level.

Parameters:
- W, 8, sample/bin component width (two's complement); must match the core's width.
- CORE_LAT, 1, core register latency in clk cycles (1..7).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- s_valid  input  1  input sample valid
- s_ready  output  1  sequencer accepts input sample (registered)
- s_re  input  W  input sample, real part
- s_im  input  W  input sample, imaginary part
- m_valid  output  1  output bin valid
- m_ready  input  1  consumer accepts output bin
- m_re  output  W  output bin, real part
- m_im  output  W  output bin, imaginary part
- m_idx  output  3  bin index 0..7 of the current m_re/m_im
- m_last  output  1  high with bin 7
- busy  output  1  high outside LOAD, or in LOAD once at least one sample is held
- core_in_re  output  8*W  frame real parts to core; sample k at [W*k+W-1:W*k] (k=0 maps to core a, k=7 to h)
- core_in_im  output  8*W  frame imaginary parts, same packing
- core_out_re  input  8*W  core result real parts; bin k at [W*k+W-1:W*k] (fft_a=X0 ... fft_h=X7)
- core_out_im  input  8*W  core result imaginary parts, same packing

Behaviour:
- Reset (async, while rst=1):
  - State=LOAD; sample counter, wait counter and bin index = 0.
  - Input and output buffers cleared; core_in_* = 0.
  - s_ready=0, m_valid=0, m_re/m_im=0, m_idx=0, m_last=0, busy=0.
  - s_ready rises at the first clk edge after rst deasserts.
- States: LOAD -> WAIT -> UNLOAD -> LOAD.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: ibuf[cnt] <= {s_re, s_im}; cnt++.
  - Acceptance of sample 7 (edge T) -> WAIT, with s_ready low from edge T. Wait counter loads CORE_LAT.
- WAIT:
  - core_in_* held stable from ibuf. The wait counter decrements each edge.
  - At edge T+CORE_LAT+1: obuf <= core_out_*; state -> UNLOAD; m_valid=1 after that edge.
  - s_valid ignored.
- UNLOAD:
  - m_re/m_im = obuf[m_idx]; m_last = (m_idx==7).
  - Outputs hold stable while m_valid&&!m_ready.
  - On handshake: m_idx++. On the bin-7 handshake: m_valid=0, m_idx=0, cnt=0, state -> LOAD; s_ready=1 from that edge.
- No overlap between frames; minimum frame period is 8 + CORE_LAT + 1 + 8 cycles.
- core_in_* change only on LOAD-state writes. Unwritten slots hold the previous frame's values but are fully overwritten before WAIT.
- Arithmetic: the sequencer performs none; values pass bit-exact. Overflow and wrap behaviour is the core's.
- s_valid=1 outside LOAD: no accept, no state change. m_ready=1 while m_valid=0: no effect.
- Reset mid-frame in any state: the partial frame and pending bins are discarded; the block returns to the reset values above.

Optional Feature:
- Macro FFT_SEQ_FRAMECNT_EN. When defined, adds output frame_cnt [15:0].
  - Resets to 0; increments by 1 on each bin-7 output handshake; wraps 0xFFFF -> 0.
  - Unaffected by s_valid activity outside LOAD.
- When undefined, the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Impulse: samples (1,0),(0,0)x7, m_ready=1 -> 8 bins all (1,0); m_idx 0..7; m_last only at idx 7; first m_valid CORE_LAT+1 edges after the edge accepting sample 7.
- DC: eight samples (2,0) -> X0=(16,0), X1..X7=(0,0).
- Alternating: re=1,-1,1,-1,1,-1,1,-1, im=0 -> X4 (m_idx=4) = (8,0), all others (0,0); s_ready=0 from last accept until the bin-7 handshake.
- Backpressure: DC frame, m_ready toggles 1,0,0,1,... -> bins delivered in order, each held stable while m_ready=0, no drop or duplicate; s_valid=1 during UNLOAD accepts nothing.
- Reset mid-UNLOAD: assert rst after bin 3 handshake -> m_valid=0 immediately, all outputs 0. Next impulse frame yields all (1,0) bins from m_idx 0.
- FFT_SEQ_FRAMECNT_EN defined, 3 back-to-back frames -> frame_cnt 0,1,2,3, each step at the bin-7 handshake.
